regbank_mp: RTL and testbench

Parametrised successor to the single-port 8-bit register bank; the CPU datapath's general-purpose register file.
- Two independent read ports (A, B) feed the ALU operand paths; one write port.
- Register 0 is hardwired to zero.
- Built-in clear sequencer zeroes the whole bank on request over multiple cycles, with a busy indication to the control unit.

---
 rtl/regbank_pkg.sv | 17 +
 rtl/regbank_clear_seq.sv | 79 +++++++
 rtl/regbank_mp.sv | 93 +++++++++
 tb/tb_regbank_mp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared types and constants for the multi-port register bank.
//   clr_state_e     - clear sequencer state (IDLE, CLEAR)
//   DEFAULT_DATA_W  - default register width
//   DEFAULT_ADDR_W  - default register select width
//   ZERO_REG        - index of the hardwired-zero register
package regbank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned ZERO_REG       = 0;

endpackage : regbank_pkg

// File: rtl/regbank_clear_seq.sv
// regbank_clear_seq: sweeps the register bank to zero, one register per cycle,
// starting at register 1 and finishing on the last register.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear_req   - request a bank-wide clear (ignored while a sweep is running)
//   busy        - registered, high while the sweep is in progress
//   clr_en      - storage array should zero clr_addr on this edge
//   clr_addr    - register being zeroed on this edge
module regbank_clear_seq
  import regbank_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

  clr_state_e        state_q;
  clr_state_e        state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              busy_q;
  logic              busy_d;

  // State, pointer and busy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; register 0 is never swept since it cannot hold data.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = FIRST_ADDR;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ADDR_W'(ptr_q + 1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy     = busy_q;
  assign clr_en   = (state_q == CLEAR);
  assign clr_addr = ptr_q;

endmodule : regbank_clear_seq

// File: rtl/regbank_mp.sv
// regbank_mp: general-purpose register file, two combinational read ports,
// one write port, register 0 hardwired to zero, built-in clear sequencer.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   write_reg, wsel, data_in- write port (dropped while busy or for register 0)
//   rsel_a, rsel_b          - read selects
//   data_out_a, data_out_b  - combinational read data
//   clear_req               - start a bank-wide clear sweep
//   busy                    - clear sweep in progress (registered)
// Configuration:
//   REGBANK_WRITE_BYPASS_EN - when defined, a read of the register being
//                             written returns data_in in the same cycle.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_reg,
  input  logic [ADDR_W-1:0] wsel,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rsel_a,
  input  logic [ADDR_W-1:0] rsel_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              clear_req,
  output logic              busy
);

  localparam int unsigned       NREGS    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [NREGS];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;

  regbank_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  // A write lands only while idle and never into the zero register.
  assign wr_ok = write_reg && !busy && (wsel != ZERO_SEL);

  // Storage array; a clear step and a write are mutually exclusive via busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem[i] <= '0;
      end
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[wsel] <= data_in;
    end
  end

  // Read port A.
  always_comb begin
    data_out_a = '0;
    if (rsel_a != ZERO_SEL) begin
      data_out_a = mem[rsel_a];
`ifdef REGBANK_WRITE_BYPASS_EN
      if (wr_ok && (rsel_a == wsel)) begin
        data_out_a = data_in;
      end
`endif
    end
  end

  // Read port B.
  always_comb begin
    data_out_b = '0;
    if (rsel_b != ZERO_SEL) begin
      data_out_b = mem[rsel_b];
`ifdef REGBANK_WRITE_BYPASS_EN
      if (wr_ok && (rsel_b == wsel)) begin
        data_out_b = data_in;
      end
`endif
    end
  end

endmodule : regbank_mp

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: directed and randomized checks of regbank_mp against an
// array-based reference model of the register file and clear sweep.
module tb_regbank_mp;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_reg;
  logic [AW-1:0] wsel;
  logic [DW-1:0] data_in;
  logic [AW-1:0] rsel_a;
  logic [AW-1:0] rsel_b;
  logic [DW-1:0] data_out_a;
  logic [DW-1:0] data_out_b;
  logic          clear_req;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents and registers still to be swept.
  logic [DW-1:0] model [NR];
  int            sweep_left;

  always #5 clk = ~clk;

  regbank_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_reg  (write_reg),
    .wsel       (wsel),
    .data_in    (data_in),
    .rsel_a     (rsel_a),
    .rsel_b     (rsel_b),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b),
    .clear_req  (clear_req),
    .busy       (busy)
  );

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] sel);
    if (sel == 0) return '0;
`ifdef REGBANK_WRITE_BYPASS_EN
    if (write_reg && wsel == sel && sweep_left == 0) return data_in;
`endif
    return model[sel];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one rising edge to the model using the inputs present at the edge.
  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
      sweep_left = 0;
    end else if (sweep_left > 0) begin
      model[NR - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (write_reg && wsel != 0) model[wsel] = data_in;
      if (clear_req) sweep_left = NR - 1;
    end
  endtask

  // Drive one cycle, check reads and busy before the edge, then take the edge.
  task automatic step(input logic we, input logic [AW-1:0] ws, input logic [DW-1:0] d,
                      input logic cr, input logic rn,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    write_reg = we; wsel = ws; data_in = d; clear_req = cr; rst_n = rn;
    rsel_a = ra; rsel_b = rb;
    #2;
    check("read_a", 32'(data_out_a), 32'(exp_read(ra)));
    check("read_b", 32'(data_out_b), 32'(exp_read(rb)));
    check("busy", 32'(busy), 32'(sweep_left > 0));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_step(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(1'b0, '0, '0, 1'b0, 1'b1, ra, rb);
  endtask

  task automatic read_all();
    for (int i = 0; i < NR; i++) idle_step(AW'(i), AW'(NR - 1 - i));
  endtask

  task automatic fill_random();
    for (int i = 1; i < NR; i++)
      step(1'b1, AW'(i), DW'($urandom_range(1, 255)), 1'b0, 1'b1, AW'(i), '0);
  endtask

  initial begin
    int busy_cnt;
    logic [DW-1:0] keep20;

    for (int i = 0; i < NR; i++) model[i] = '0;
    sweep_left = 0;
    write_reg = 1'b0; wsel = '0; data_in = '0; clear_req = 1'b0;
    rsel_a = '0; rsel_b = '0; rst_n = 1'b0;
    @(posedge clk); model_edge(); #1;
    @(posedge clk); model_edge(); #1;

    // Reset state.
    read_all();
    check("reset_busy", 32'(busy), 32'd0);

    // Zero register swallows writes.
    step(1'b1, '0, 8'h05, 1'b0, 1'b1, '0, '0);
    check("zero_reg", 32'(data_out_a), 32'h00);

    // Dual read in the same cycle.
    step(1'b1, 5'd1, 8'h05, 1'b0, 1'b1, 5'd1, 5'd2);
    step(1'b1, 5'd2, 8'hA3, 1'b0, 1'b1, 5'd1, 5'd2);
    idle_step(5'd1, 5'd2);
    check("dual_a", 32'(data_out_a), 32'h05);
    check("dual_b", 32'(data_out_b), 32'hA3);

    // Write timing: pre-edge value checked inside step, post-edge here.
    step(1'b1, 5'd3, 8'h7E, 1'b0, 1'b1, 5'd3, 5'd3);
    idle_step(5'd3, 5'd0);
    check("wr_after_edge", 32'(data_out_a), 32'h7E);

    // Clear sweep with mid-sweep probe at cycle 10.
    fill_random();
    keep20 = model[20];
    step(1'b0, '0, '0, 1'b1, 1'b1, '0, '0);
    busy_cnt = 0;
    for (int k = 1; k <= 34; k++) begin
      if (busy) busy_cnt++;
      if (k == 10) begin
        idle_step(5'd5, 5'd20);
        check("mid_reg5", 32'(data_out_a), 32'h00);
        check("mid_reg20", 32'(data_out_b), 32'(keep20));
      end else begin
        idle_step(AW'($urandom), AW'($urandom));
      end
    end
    check("busy_cycles", 32'(busy_cnt), 32'd31);
    read_all();

    // Busy interlock: writes and clear requests during the sweep are ignored.
    fill_random();
    step(1'b0, '0, '0, 1'b1, 1'b1, '0, '0);
    busy_cnt = 0;
    for (int k = 1; k <= 34; k++) begin
      if (busy) busy_cnt++;
      if (k == 2) step(1'b1, 5'd31, 8'hFF, 1'b1, 1'b1, 5'd31, 5'd1);
      else if (k == 20) step(1'b1, 5'd1, 8'hFF, 1'b0, 1'b1, 5'd1, 5'd31);
      else if (k == 30) step(1'b0, '0, '0, 1'b1, 1'b1, 5'd31, 5'd1);
      else idle_step(5'd31, 5'd1);
    end
    check("interlock_busy_cycles", 32'(busy_cnt), 32'd31);
    check("interlock_reg31", 32'(data_out_a), 32'h00);
    check("interlock_reg1", 32'(data_out_b), 32'h00);

    // Reset in the middle of a sweep.
    fill_random();
    step(1'b0, '0, '0, 1'b1, 1'b1, '0, '0);
    for (int k = 1; k < 15; k++) idle_step(5'd20, 5'd31);
    step(1'b0, '0, '0, 1'b0, 1'b0, 5'd20, 5'd31);
    check("rst_busy", 32'(busy), 32'd0);
    read_all();
    step(1'b1, 5'd4, 8'h3C, 1'b0, 1'b1, 5'd4, 5'd0);
    idle_step(5'd4, 5'd4);
    check("post_rst_write", 32'(data_out_a), 32'h3C);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) != 0),
           AW'($urandom), AW'($urandom));
    end
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regbank_mp
